// File: rtl/exotiny_wb_arb.sv
// exotiny_wb_arb: round-robin arbiter sharing one Wishbone slave between two masters.
// Define EXOTINY_ARB_TIMEOUT_EN to build the no-ack watchdog (limit = TIMEOUT cycles).
module exotiny_wb_arb #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [31:0]   m0_wdat_i,
  input  logic [3:0]    m0_sel_i,
  output logic [31:0]   m0_rdat_o,
  output logic          m0_ack_o,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [31:0]   m1_wdat_i,
  input  logic [3:0]    m1_sel_i,
  output logic [31:0]   m1_rdat_o,
  output logic          m1_ack_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [AW-1:0] s_adr_o,
  output logic [31:0]   s_wdat_o,
  output logic [3:0]    s_sel_o,
  input  logic [31:0]   s_rdat_i,
  input  logic          s_ack_i,
  output logic [1:0]    gnt_o,
  output logic          tout_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  // rr = 1 means m1 wins the next tie
  logic   rr;
  logic   rr_nxt;
  logic   mstb;
  logic   tout;

  assign mstb = (state == GNT0) ? m0_stb_i :
                (state == GNT1) ? m1_stb_i : 1'b0;

`ifdef EXOTINY_ARB_TIMEOUT_EN
  logic [15:0] cnt;

  // Watchdog: counts unacknowledged cycles of the current grant
  always_ff @(posedge clk_i) begin
    if (rst_i || state == IDLE) begin
      cnt <= '0;
    end else if (!s_ack_i) begin
      cnt <= cnt + 16'd1;
    end
  end

  // A real ack in the limit cycle wins over the abort
  assign tout = mstb && !s_ack_i &&
                (cnt == 16'(TIMEOUT));
`else
  logic unused_timeout;

  assign unused_timeout = |16'(TIMEOUT);
  assign tout = 1'b0;
`endif

  // Grant state and round-robin pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      rr    <= 1'b0;
    end else begin
      state <= state_nxt;
      rr    <= rr_nxt;
    end
  end

  // Arbitration: grant held until ack, abort or watchdog
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr;
    unique case (state)
      IDLE: begin
        if (m0_stb_i && m1_stb_i) begin
          state_nxt = rr ? GNT1 : GNT0;
        end else if (m0_stb_i) begin
          state_nxt = GNT0;
        end else if (m1_stb_i) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        if (!m0_stb_i) begin
          state_nxt = IDLE;
        end else if (s_ack_i || tout) begin
          state_nxt = IDLE;
          rr_nxt    = 1'b1;
        end
      end
      GNT1: begin
        if (!m1_stb_i) begin
          state_nxt = IDLE;
        end else if (s_ack_i || tout) begin
          state_nxt = IDLE;
          rr_nxt    = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus steering: slave side from the owner, ack/rdat back to it only
  always_comb begin
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = '0;
    s_wdat_o  = '0;
    s_sel_o   = '0;
    m0_ack_o  = 1'b0;
    m0_rdat_o = '0;
    m1_ack_o  = 1'b0;
    m1_rdat_o = '0;
    unique case (state)
      GNT0: begin
        s_stb_o   = m0_stb_i && !tout;
        s_we_o    = m0_we_i;
        s_adr_o   = m0_adr_i;
        s_wdat_o  = m0_wdat_i;
        s_sel_o   = m0_sel_i;
        m0_ack_o  = s_ack_i || tout;
        m0_rdat_o = tout ? 32'h0 : s_rdat_i;
      end
      GNT1: begin
        s_stb_o   = m1_stb_i && !tout;
        s_we_o    = m1_we_i;
        s_adr_o   = m1_adr_i;
        s_wdat_o  = m1_wdat_i;
        s_sel_o   = m1_sel_i;
        m1_ack_o  = s_ack_i || tout;
        m1_rdat_o = tout ? 32'h0 : s_rdat_i;
      end
      default: ;
    endcase
  end

  assign gnt_o  = {state == GNT1, state == GNT0};
  assign tout_o = tout;

endmodule
